// File: rtl/retire_monitor_pkg.sv
// Shared constants for the retirement monitor: FSM encodings and counter selects.
package retire_monitor_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned SEL_W = 2;

  // FSM state encodings
  localparam logic [ST_W-1:0] IDLE   = 2'd0;
  localparam logic [ST_W-1:0] RUN    = 2'd1;
  localparam logic [ST_W-1:0] HALTED = 2'd2;

  // Counter read-port selects
  localparam logic [SEL_W-1:0] SEL_CYCLE   = 2'd0;
  localparam logic [SEL_W-1:0] SEL_INSN    = 2'd1;
  localparam logic [SEL_W-1:0] SEL_CTRL    = 2'd2;
  localparam logic [SEL_W-1:0] SEL_MISPRED = 2'd3;

endpackage

// File: rtl/retire_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  // Count register: clear wins over increment, increment stops at MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/retire_monitor.sv
// Writeback retirement monitor: registered debug outputs, performance
// counters that start on first retirement and freeze at the halt PC.
module retire_monitor
  import retire_monitor_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] HALT_PC = 32'h0000_001C
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_vld,
  input  logic             i_wb_flush,
  input  logic [31:0]      i_wb_pc,
  input  logic             i_wb_is_ctrl,
  input  logic             i_wb_mispred,
  input  logic             i_clr,
  input  logic [1:0]       i_cnt_sel,
  output logic             o_insn_vld,
  output logic [31:0]      o_pc_debug,
  output logic             o_ctrl,
  output logic             o_mispred,
  output logic             o_halt,
  output logic [CNT_W-1:0] o_cnt_data
);

  logic            ret;
  logic            ret_ctrl;
  logic            ret_mis;
  logic            at_halt_pc;
  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic            inc_cycle;
  logic            inc_insn;
  logic            inc_ctrl;
  logic            inc_mis;
  logic [CNT_W-1:0] cnt_cycle;
  logic [CNT_W-1:0] cnt_insn;
  logic [CNT_W-1:0] cnt_ctrl;
  logic [CNT_W-1:0] cnt_mis;

  assign ret        = i_wb_vld & ~i_wb_flush;
  assign ret_ctrl   = ret & i_wb_is_ctrl;
  assign ret_mis    = ret_ctrl & i_wb_mispred;
  assign at_halt_pc = (i_wb_pc == HALT_PC);

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and counter enables; clear overrides everything
  always_comb begin
    state_nxt = state;
    inc_cycle = 1'b0;
    inc_insn  = 1'b0;
    inc_ctrl  = 1'b0;
    inc_mis   = 1'b0;
    case (state)
      IDLE: begin
        if (ret) begin
          inc_cycle = 1'b1;
          inc_insn  = 1'b1;
          inc_ctrl  = ret_ctrl;
          inc_mis   = ret_mis;
          state_nxt = at_halt_pc ? HALTED : RUN;
        end
      end
      RUN: begin
        inc_cycle = 1'b1;
        inc_insn  = ret;
        inc_ctrl  = ret_ctrl;
        inc_mis   = ret_mis;
        if (ret && at_halt_pc) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (i_clr) begin
      state_nxt = IDLE;
    end
  end

  // Halt flag mirrors the registered HALTED state
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_halt <= 1'b0;
    end else begin
      o_halt <= (state_nxt == HALTED);
    end
  end

  // Per-instruction debug outputs, independent of FSM state and clear
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_insn_vld <= 1'b0;
      o_ctrl     <= 1'b0;
      o_mispred  <= 1'b0;
      o_pc_debug <= '0;
    end else begin
      o_insn_vld <= ret;
      o_ctrl     <= ret_ctrl;
      o_mispred  <= ret_mis;
      if (ret) begin
        o_pc_debug <= i_wb_pc;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_cycle (
    .clk(i_clk), .rst_n(i_reset), .clr(i_clr), .inc(inc_cycle), .q(cnt_cycle)
  );
  sat_counter #(.W(CNT_W)) u_cnt_insn (
    .clk(i_clk), .rst_n(i_reset), .clr(i_clr), .inc(inc_insn), .q(cnt_insn)
  );
  sat_counter #(.W(CNT_W)) u_cnt_ctrl (
    .clk(i_clk), .rst_n(i_reset), .clr(i_clr), .inc(inc_ctrl), .q(cnt_ctrl)
  );
  sat_counter #(.W(CNT_W)) u_cnt_mis (
    .clk(i_clk), .rst_n(i_reset), .clr(i_clr), .inc(inc_mis), .q(cnt_mis)
  );

  // Counter read port, combinational on the registered counts
  always_comb begin
    o_cnt_data = cnt_cycle;
    case (i_cnt_sel)
      SEL_CYCLE:   o_cnt_data = cnt_cycle;
      SEL_INSN:    o_cnt_data = cnt_insn;
      SEL_CTRL:    o_cnt_data = cnt_ctrl;
      SEL_MISPRED: o_cnt_data = cnt_mis;
      default:     o_cnt_data = cnt_cycle;
    endcase
  end

endmodule

// File: tb/tb_retire_monitor.sv
// Directed bench for retire_monitor: a 32-bit and a 4-bit instance share stimulus.
module tb_retire_monitor;

  logic        clk;
  logic        rst_n;
  logic        wb_vld;
  logic        wb_flush;
  logic [31:0] wb_pc;
  logic        wb_is_ctrl;
  logic        wb_mispred;
  logic        clr;
  logic [1:0]  cnt_sel;

  logic        insn_vld, ctrl, mispred, halt;
  logic [31:0] pc_debug;
  logic [31:0] cnt_data;
  logic        insn_vld4, ctrl4, mispred4, halt4;
  logic [31:0] pc_debug4;
  logic [3:0]  cnt_data4;

  int tests;
  int fails;

  retire_monitor #(.CNT_W(32), .HALT_PC(32'h0000_001C)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wb_vld(wb_vld), .i_wb_flush(wb_flush),
    .i_wb_pc(wb_pc), .i_wb_is_ctrl(wb_is_ctrl), .i_wb_mispred(wb_mispred),
    .i_clr(clr), .i_cnt_sel(cnt_sel), .o_insn_vld(insn_vld), .o_pc_debug(pc_debug),
    .o_ctrl(ctrl), .o_mispred(mispred), .o_halt(halt), .o_cnt_data(cnt_data)
  );

  retire_monitor #(.CNT_W(4), .HALT_PC(32'h0000_001C)) dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_wb_vld(wb_vld), .i_wb_flush(wb_flush),
    .i_wb_pc(wb_pc), .i_wb_is_ctrl(wb_is_ctrl), .i_wb_mispred(wb_mispred),
    .i_clr(clr), .i_cnt_sel(cnt_sel), .o_insn_vld(insn_vld4), .o_pc_debug(pc_debug4),
    .o_ctrl(ctrl4), .o_mispred(mispred4), .o_halt(halt4), .o_cnt_data(cnt_data4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reads all four counters of the 32-bit instance within the current cycle
  task automatic chk_cnt(input string tag, input logic [31:0] cy, input logic [31:0] in,
                         input logic [31:0] ct, input logic [31:0] mp);
    cnt_sel = 2'd0; #1; chk({tag, ".cycle"}, cnt_data, cy);
    cnt_sel = 2'd1; #1; chk({tag, ".insn"}, cnt_data, in);
    cnt_sel = 2'd2; #1; chk({tag, ".ctrl"}, cnt_data, ct);
    cnt_sel = 2'd3; #1; chk({tag, ".mispred"}, cnt_data, mp);
  endtask

  task automatic chk_cnt4(input string tag, input logic [3:0] cy, input logic [3:0] in);
    cnt_sel = 2'd0; #1; chk({tag, ".cycle4"}, 32'(cnt_data4), 32'(cy));
    cnt_sel = 2'd1; #1; chk({tag, ".insn4"}, 32'(cnt_data4), 32'(in));
  endtask

  task automatic drv(input logic v, input logic f, input logic [31:0] pc,
                     input logic c, input logic m);
    wb_vld = v; wb_flush = f; wb_pc = pc; wb_is_ctrl = c; wb_mispred = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    cnt_sel = 2'd0;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    chk("rst.insn_vld", 32'(insn_vld), 32'd0);
    chk("rst.halt", 32'(halt), 32'd0);
    chk("rst.pc", pc_debug, 32'h0);
    rst_n = 1'b1;

    // Idle 5 cycles: nothing counts
    repeat (5) tick();
    chk_cnt("idle", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("idle.halt", 32'(halt), 32'd0);

    // Straight-line retirements, halt on the 8th (PC 0x1C)
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 1'b0, 32'(i * 4), 1'b0, 1'b0);
      tick();
      if (i == 6) chk("line.halt_pre", 32'(halt), 32'd0);
      if (i == 7) begin
        chk("line.halt", 32'(halt), 32'd1);
        chk_cnt("line.at_halt", 32'd8, 32'd8, 32'd0, 32'd0);
      end
    end
    chk_cnt("line.frozen", 32'd8, 32'd8, 32'd0, 32'd0);
    chk("line.pc_track", pc_debug, 32'h24);
    chk("line.vld_track", 32'(insn_vld), 32'd1);
    chk("line.halt_hold", 32'(halt), 32'd1);

    // Mixed stream: 6 retirements, 2 branches (1 mispredicted), 2 flushes, 1 bubble
    do_clr();
    chk("clr.halt", 32'(halt), 32'd0);
    chk_cnt("clr", 32'd0, 32'd0, 32'd0, 32'd0);
    drv(1'b1, 1'b0, 32'h100, 1'b0, 1'b0); tick();
    drv(1'b1, 1'b0, 32'h104, 1'b1, 1'b0); tick();
    chk("mix.ctrl", 32'(ctrl), 32'd1);
    chk("mix.ctrl_nomis", 32'(mispred), 32'd0);
    drv(1'b1, 1'b1, 32'h108, 1'b1, 1'b1); tick();
    chk("mix.flush_vld", 32'(insn_vld), 32'd0);
    chk("mix.flush_mis", 32'(mispred), 32'd0);
    chk("mix.flush_pc", pc_debug, 32'h104);
    drv(1'b1, 1'b0, 32'h10C, 1'b0, 1'b1); tick();
    chk("mix.mis_noctrl", 32'(mispred), 32'd0);
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    drv(1'b1, 1'b0, 32'h110, 1'b1, 1'b1); tick();
    chk("mix.mis", 32'(mispred), 32'd1);
    drv(1'b1, 1'b1, 32'h114, 1'b0, 1'b0); tick();
    chk("mix.flush2_vld", 32'(insn_vld), 32'd0);
    drv(1'b1, 1'b0, 32'h118, 1'b0, 1'b0); tick();
    drv(1'b1, 1'b0, 32'h120, 1'b0, 1'b0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_cnt("mix", 32'd9, 32'd6, 32'd2, 32'd1);

    // Debug timing for a single retirement at 0x40
    drv(1'b1, 1'b0, 32'h40, 1'b0, 1'b0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("dbg.vld_n", 32'(insn_vld), 32'd1);
    chk("dbg.pc_n", pc_debug, 32'h40);
    tick();
    chk("dbg.vld_n1", 32'(insn_vld), 32'd0);
    chk("dbg.pc_n1", pc_debug, 32'h40);

    // Saturation: 20 retirements without halting
    do_clr();
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
      tick();
    end
    chk_cnt4("sat", 4'd15, 4'd15);
    chk("sat.halt4", 32'(halt4), 32'd0);
    chk_cnt("sat.wide", 32'd20, 32'd20, 32'd0, 32'd0);
    drv(1'b1, 1'b0, 32'h1C, 1'b0, 1'b0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat.halt4_after", 32'(halt4), 32'd1);
    chk_cnt4("sat.held", 4'd15, 4'd15);

    // First retirement at HALT_PC goes straight to HALTED and is counted
    do_clr();
    drv(1'b1, 1'b0, 32'h1C, 1'b1, 1'b0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("direct.halt", 32'(halt), 32'd1);
    chk_cnt("direct", 32'd1, 32'd1, 32'd1, 32'd0);

    // Clear coincident with the HALT_PC retirement
    do_clr();
    drv(1'b1, 1'b0, 32'h10, 1'b0, 1'b0); tick();
    drv(1'b1, 1'b0, 32'h14, 1'b0, 1'b0); tick();
    drv(1'b1, 1'b0, 32'h1C, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("clrhalt.halt", 32'(halt), 32'd0);
    chk("clrhalt.vld", 32'(insn_vld), 32'd1);
    chk("clrhalt.pc", pc_debug, 32'h1C);
    chk_cnt("clrhalt", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk_cnt("clrhalt.idle", 32'd0, 32'd0, 32'd0, 32'd0);

    // Asynchronous reset pulse mid-run, away from a clock edge
    drv(1'b1, 1'b0, 32'h300, 1'b1, 1'b1); tick();
    tick();
    chk_cnt("pre_rst", 32'd2, 32'd2, 32'd2, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.vld", 32'(insn_vld), 32'd0);
    chk("arst.ctrl", 32'(ctrl), 32'd0);
    chk("arst.mis", 32'(mispred), 32'd0);
    chk("arst.pc", pc_debug, 32'h0);
    chk("arst.halt", 32'(halt), 32'd0);
    cnt_sel = 2'd0; #1; chk("arst.cycle", cnt_data, 32'd0);
    cnt_sel = 2'd1; #1; chk("arst.insn", cnt_data, 32'd0);
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    chk_cnt("post_rst", 32'd0, 32'd0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
